// File: rtl/bp_be_host_mmio_arbiter.sv
// rtl/bp_be_host_mmio_arbiter.sv - per-core MMIO store FIFOs round-robin merged onto one host channel
module bp_be_host_mmio_arbiter #(
    parameter int num_core_p    = 2,
    parameter int vaddr_width_p = 64,
    parameter int fifo_els_p    = 4,
    localparam int core_w       = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [num_core_p-1:0]                 cmt_v_i,
    input  logic [num_core_p*vaddr_width_p-1:0]   cmt_addr_i,
    input  logic [num_core_p*32-1:0]              cmt_data_i,
    output logic [num_core_p-1:0]                 cmt_ready_o,
    output logic                                  host_v_o,
    output logic [2:0]                            host_cmd_o,
    output logic [core_w-1:0]                     host_core_o,
    output logic [15:0]                           host_data_o,
    input  logic                                  host_yumi_i,
    output logic [num_core_p-1:0]                 core_done_o,
    output logic                                  done_o,
    output logic                                  pass_o
);

    localparam int ptr_w = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w = $clog2(fifo_els_p + 1);

    localparam logic [2:0] cmd_prt_dec = 3'd0;
    localparam logic [2:0] cmd_prt_chr = 3'd1;
    localparam logic [2:0] cmd_pas     = 3'd2;
    localparam logic [2:0] cmd_fal     = 3'd3;
    localparam logic [2:0] cmd_err     = 3'd4;

    localparam logic [vaddr_width_p-1:0] fin_addr = vaddr_width_p'(64'hC00D_EAD0);
    localparam logic [vaddr_width_p-1:0] dec_addr = vaddr_width_p'(64'h8FFF_FFFF);
    localparam logic [vaddr_width_p-1:0] chr_addr = vaddr_width_p'(64'h8FFF_EFFF);

    logic [num_core_p-1:0]        push;
    logic [num_core_p-1:0]        pop;
    logic [num_core_p-1:0]        empty;
    logic [num_core_p-1:0][18:0]  head;

    logic [core_w-1:0]            rr_ptr;
    logic                         grant_v;
    logic [core_w-1:0]            grant_id;
    logic                         load;
    logic                         fail;
    int                           arb_idx;

    for (genvar i = 0; i < num_core_p; i++) begin : g_core
        logic [vaddr_width_p-1:0] addr;
        logic [31:0]              data;
        logic                     dec_v;
        logic                     dec_fin;
        logic [2:0]               dec_cmd;
        logic [15:0]              dec_data;
        logic                     finished;
        logic [cnt_w-1:0]         count;
        logic [ptr_w-1:0]         wptr;
        logic [ptr_w-1:0]         rptr;
        logic [18:0]              mem [fifo_els_p];

        assign addr = cmt_addr_i[i*vaddr_width_p +: vaddr_width_p];
        assign data = cmt_data_i[i*32 +: 32];

        // Classify the store; unknown addresses produce no record
        always_comb begin
            dec_v    = 1'b0;
            dec_fin  = 1'b0;
            dec_cmd  = cmd_prt_dec;
            dec_data = 16'h0000;
            if (addr == fin_addr) begin
                dec_v   = 1'b1;
                dec_fin = 1'b1;
                if (data[31:16] == 16'h0000) begin
                    dec_cmd  = cmd_pas;
                    dec_data = data[15:0];
                end else if (data[31:16] == 16'hFFFF) begin
                    dec_cmd  = cmd_fal;
                    dec_data = data[15:0];
                end else begin
                    dec_cmd  = cmd_err;
                end
            end else if (addr == dec_addr) begin
                dec_v    = 1'b1;
                dec_cmd  = cmd_prt_dec;
                dec_data = {8'h00, data[7:0]};
            end else if (addr == chr_addr) begin
                dec_v    = 1'b1;
                dec_cmd  = cmd_prt_chr;
                dec_data = {8'h00, data[7:0]};
            end
        end

        assign cmt_ready_o[i] = (count != cnt_w'(fifo_els_p));
        assign push[i]        = cmt_v_i[i] & cmt_ready_o[i] & dec_v & ~finished;
        assign empty[i]       = (count == '0);
        assign head[i]        = mem[rptr];

        // FIFO pointers, occupancy and the post-finish drop flag
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                count    <= '0;
                wptr     <= '0;
                rptr     <= '0;
                finished <= 1'b0;
            end else begin
                if (push[i]) begin
                    wptr <= (wptr == ptr_w'(fifo_els_p - 1)) ? '0 : wptr + 1'b1;
                    if (dec_fin) finished <= 1'b1;
                end
                if (pop[i]) begin
                    rptr <= (rptr == ptr_w'(fifo_els_p - 1)) ? '0 : rptr + 1'b1;
                end
                case ({push[i], pop[i]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        // FIFO storage holds {cmd, data}; contents need no reset
        always_ff @(posedge clk_i) begin
            if (push[i]) mem[wptr] <= {dec_cmd, dec_data};
        end
    end

    // Round-robin search for the first non-empty FIFO starting at rr_ptr
    always_comb begin
        grant_v  = 1'b0;
        grant_id = '0;
        arb_idx  = 0;
        for (int k = num_core_p - 1; k >= 0; k--) begin
            arb_idx = int'(rr_ptr) + k;
            if (arb_idx >= num_core_p) arb_idx = arb_idx - num_core_p;
            if (!empty[core_w'(arb_idx)]) begin
                grant_v  = 1'b1;
                grant_id = core_w'(arb_idx);
            end
        end
    end

    assign load = (~host_v_o | host_yumi_i) & grant_v;

    always_comb begin
        pop = '0;
        if (load) pop[grant_id] = 1'b1;
    end

    // Host output register and round-robin pointer
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            host_v_o    <= 1'b0;
            host_cmd_o  <= '0;
            host_core_o <= '0;
            host_data_o <= '0;
            rr_ptr      <= '0;
        end else if (load) begin
            host_v_o    <= 1'b1;
            host_cmd_o  <= head[grant_id][18:16];
            host_core_o <= grant_id;
            host_data_o <= head[grant_id][15:0];
            rr_ptr      <= (grant_id == core_w'(num_core_p - 1)) ? '0 : grant_id + 1'b1;
        end else if (host_yumi_i) begin
            host_v_o <= 1'b0;
        end
    end

    // Sticky completion and failure tracking on consumed finish records
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            core_done_o <= '0;
            fail        <= 1'b0;
        end else if (host_v_o && host_yumi_i) begin
            if (host_cmd_o == cmd_pas || host_cmd_o == cmd_fal || host_cmd_o == cmd_err)
                core_done_o[host_core_o] <= 1'b1;
            if (host_cmd_o == cmd_fal || host_cmd_o == cmd_err)
                fail <= 1'b1;
        end
    end

    assign done_o = &core_done_o;
    assign pass_o = done_o & ~fail;

endmodule

// File: tb/tb_bp_be_host_mmio_arbiter.sv
// tb/tb_bp_be_host_mmio_arbiter.sv - scoreboard bench for the host MMIO arbiter
module tb_bp_be_host_mmio_arbiter;

    localparam logic [63:0] a_fin = 64'hC00D_EAD0;
    localparam logic [63:0] a_dec = 64'h8FFF_FFFF;
    localparam logic [63:0] a_chr = 64'h8FFF_EFFF;
    localparam logic [63:0] a_oth = 64'h8000_0000;

    logic          clk;
    logic          reset_n;
    logic [1:0]    cmt_v;
    logic [127:0]  cmt_addr;
    logic [63:0]   cmt_data;
    logic [1:0]    cmt_ready;
    logic          host_v;
    logic [2:0]    host_cmd;
    logic [0:0]    host_core;
    logic [15:0]   host_data;
    logic          host_yumi;
    logic [1:0]    core_done;
    logic          done;
    logic          pass;

    int tests = 0;
    int fails = 0;
    logic [19:0] sb [$];

    bp_be_host_mmio_arbiter #(
        .num_core_p(2),
        .vaddr_width_p(64),
        .fifo_els_p(4)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .cmt_v_i(cmt_v),
        .cmt_addr_i(cmt_addr),
        .cmt_data_i(cmt_data),
        .cmt_ready_o(cmt_ready),
        .host_v_o(host_v),
        .host_cmd_o(host_cmd),
        .host_core_o(host_core),
        .host_data_o(host_data),
        .host_yumi_i(host_yumi),
        .core_done_o(core_done),
        .done_o(done),
        .pass_o(pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_rec(input logic [2:0] cmd, input logic core, input logic [15:0] data);
        sb.push_back({cmd, core, data});
    endtask

    // Monitor: every consumed record must match the head of the scoreboard
    always @(negedge clk) begin
        if (reset_n && host_v && host_yumi) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_record: got %0h expected none", {host_cmd, host_core, host_data});
            end else begin
                check("host_record", 32'({host_cmd, host_core, host_data}), 32'(sb.pop_front()));
            end
        end
    end

    task automatic store(input logic [1:0] v, input logic [63:0] a0, input logic [31:0] d0,
                         input logic [63:0] a1, input logic [31:0] d1);
        cmt_v    = v;
        cmt_addr = {a1, a0};
        cmt_data = {d1, d0};
        @(posedge clk);
        #1;
        cmt_v = 2'b00;
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        cmt_v     = 2'b00;
        host_yumi = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 60; c++) begin
            if (sb.size() == 0 && !host_v) break;
            @(posedge clk);
            #1;
        end
        check(name, 32'(sb.size() == 0 && !host_v), 32'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        cmt_v     = 2'b00;
        cmt_addr  = '0;
        cmt_data  = '0;
        host_yumi = 1'b0;
        #2;
        check("reset_host_v", 32'(host_v), 32'd0);
        check("reset_outputs", 32'({host_cmd, host_core, host_data}), 32'd0);
        check("reset_done", 32'({core_done, done, pass}), 32'd0);
        check("reset_ready", 32'(cmt_ready), 32'd3);
        @(posedge clk);
        #1;
        apply_reset();

        // Single character print: visible two edges after the accepting edge
        host_yumi = 1'b1;
        expect_rec(3'd1, 1'b0, 16'h0041);
        store(2'b01, a_chr, 32'h0000_0041, 64'd0, 32'd0);
        check("lat_not_yet", 32'(host_v), 32'd0);
        @(posedge clk); #1;
        check("lat_valid", 32'({host_v, host_cmd, host_core, host_data}), 32'({1'b1, 3'd1, 1'b0, 16'h0041}));
        @(posedge clk); #1;
        check("lat_gone", 32'(host_v), 32'd0);
        wait_drain("drain_single");

        // Round-robin fairness from a fresh pointer
        apply_reset();
        host_yumi = 1'b1;
        expect_rec(3'd0, 1'b0, 16'h0010);
        expect_rec(3'd0, 1'b1, 16'h0020);
        expect_rec(3'd0, 1'b0, 16'h0011);
        expect_rec(3'd0, 1'b1, 16'h0021);
        expect_rec(3'd0, 1'b0, 16'h0012);
        expect_rec(3'd0, 1'b1, 16'h0022);
        for (int k = 0; k < 3; k++)
            store(2'b11, a_dec, 32'h1234_5610 + k, a_dec, 32'hABCD_EF20 + k);
        wait_drain("drain_rr");

        // Backpressure until full, hold, then drain in order
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            expect_rec(3'd1, 1'b0, 16'h0031 + 16'(k));
            store(2'b01, a_chr, 32'h31 + k, 64'd0, 32'd0);
        end
        check("full_ready", 32'(cmt_ready), 32'd2);
        store(2'b01, a_chr, 32'h0000_0077, 64'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            check("hold_stable", 32'({host_v, host_cmd, host_data}), 32'({1'b1, 3'd1, 16'h0031}));
            @(posedge clk); #1;
        end
        host_yumi = 1'b1;
        wait_drain("drain_full");
        check("ready_after_drain", 32'(cmt_ready), 32'd3);

        // Finish with one pass and one fail; later print dropped
        apply_reset();
        host_yumi = 1'b1;
        expect_rec(3'd2, 1'b0, 16'h0007);
        expect_rec(3'd3, 1'b1, 16'h0003);
        store(2'b11, a_fin, 32'h0000_0007, a_fin, 32'hFFFF_0003);
        wait_drain("drain_finish");
        @(posedge clk); #1;
        check("finish_status", 32'({core_done, done, pass}), 32'({2'b11, 1'b1, 1'b0}));
        store(2'b01, a_chr, 32'h0000_0055, 64'd0, 32'd0);
        check("post_finish_ready", 32'(cmt_ready), 32'd3);
        repeat (4) @(posedge clk);
        #1;
        check("post_finish_quiet", 32'(host_v), 32'd0);

        // Both cores pass
        apply_reset();
        host_yumi = 1'b1;
        expect_rec(3'd2, 1'b0, 16'h0001);
        expect_rec(3'd2, 1'b1, 16'h0002);
        store(2'b11, a_fin, 32'h0000_0001, a_fin, 32'h0000_0002);
        wait_drain("drain_pass");
        check("pass_status", 32'({core_done, done, pass}), 32'({2'b11, 1'b1, 1'b1}));

        // Unmapped store is dropped, malformed finish is ERR
        apply_reset();
        host_yumi = 1'b1;
        store(2'b01, a_oth, 32'h0000_0099, 64'd0, 32'd0);
        check("drop_ready", 32'(cmt_ready), 32'd3);
        repeat (3) @(posedge clk);
        #1;
        check("drop_quiet", 32'(host_v), 32'd0);
        expect_rec(3'd4, 1'b1, 16'h0000);
        store(2'b10, 64'd0, 32'd0, a_fin, 32'h1234_0001);
        wait_drain("drain_err");
        check("err_status", 32'({core_done, done, pass}), 32'({2'b10, 1'b0, 1'b0}));

        // Reset in the middle of traffic
        apply_reset();
        store(2'b11, a_dec, 32'h1, a_dec, 32'h2);
        store(2'b11, a_dec, 32'h3, a_dec, 32'h4);
        @(posedge clk); #1;
        check("pre_reset_valid", 32'(host_v), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_reset_outputs", 32'({host_v, host_cmd, host_core, host_data}), 32'd0);
        check("mid_reset_status", 32'({core_done, done, pass}), 32'd0);
        check("mid_reset_ready", 32'(cmt_ready), 32'd3);
        @(posedge clk); #1;
        reset_n   = 1'b1;
        host_yumi = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_reset_quiet", 32'(host_v), 32'd0);
        expect_rec(3'd1, 1'b1, 16'h005A);
        store(2'b10, 64'd0, 32'd0, a_chr, 32'h0000_015A);
        wait_drain("drain_post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bp_be_host_mmio_arbiter.md
# bp_be_host_mmio_arbiter

Synthesizable collector for committed test-harness MMIO stores (finish at 0xC00DEAD0, decimal print at 0x8FFF_FFFF, character print at 0x8FFF_EFFF) from `num_core_p` backend commit stages. Each core's records are buffered in a per-core FIFO. The block then round-robin arbitrates them onto a single registered host channel with a valid/yumi handshake, and tracks per-core and global pass/fail completion. It sits between the BE commit points and the host/testbench output port.

## Interface
- `num_core_p`, 2: number of cores; must be at least 1.
- `vaddr_width_p`, 64: committed store address width.
- `fifo_els_p`, 4: per-core FIFO depth; must be at least 2.
- `clk_i`  in  1  single clock.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `cmt_v_i`  in  `num_core_p`  per-core committed-store valid.
- `cmt_addr_i`  in  `num_core_p*vaddr_width_p`  effective address (rs1+imm), core i at slice i.
- `cmt_data_i`  in  `num_core_p*32`  rs2[31:0], core i at slice i.
- `cmt_ready_o`  out  `num_core_p`  core i may present a store. Equals ~full(i).
- `host_v_o`  out  1  host record valid (registered).
- `host_cmd_o`  out  3  0=PRT_DEC, 1=PRT_CHR, 2=PAS, 3=FAL, 4=ERR.
- `host_core_o`  out  `BSG_SAFE_CLOG2(num_core_p)`  originating core id.
- `host_data_o`  out  16  payload: test number, or character/value zero-extended from 8 bits.
- `host_yumi_i`  in  1  host consumes the record. Legal only while `host_v_o`=1.
- `core_done_o`  out  `num_core_p`  core i's finish record has been consumed.
- `done_o`  out  1  &`core_done_o`.
- `pass_o`  out  1  `done_o` and no FAL/ERR was consumed.

## Operation
- A store is accepted when `cmt_v_i[i]` & `cmt_ready_o[i]`.
- Address decode of an accepted store:
  - 0xC00DEAD0 with data[31:16]=0x0000: PAS, data[15:0].
  - 0xC00DEAD0 with data[31:16]=0xFFFF: FAL, data[15:0].
  - 0xC00DEAD0 with any other upper half: ERR, data=0.
  - 0x8FFF_FFFF: PRT_DEC, data[7:0].
  - 0x8FFF_EFFF: PRT_CHR, data[7:0].
  - Any other address is accepted and dropped; no FIFO write.
- Per-core finished flag (internal): set when a PAS/FAL/ERR record from that core is enqueued. After that, all further stores from that core are accepted and dropped.
- FIFO i stores {cmd, data}. Pointers wrap modulo `fifo_els_p`. Full when count = `fifo_els_p`. A simultaneous push and pop on a full FIFO is not possible, because ready is deasserted.
- Output register load rule: loads when (`host_v_o`=0 or `host_yumi_i`=1) and at least one FIFO is non-empty. On load, the granted FIFO is popped.
- Arbitration:
  - Round-robin starting at `rr_ptr`. Search order is `rr_ptr`, `rr_ptr`+1, …, modulo `num_core_p`.
  - After each grant to core g, `rr_ptr` becomes g+1, modulo `num_core_p`.
  - `rr_ptr` is unchanged when there is no grant.
- Consumption:
  - On `host_yumi_i` with cmd PAS/FAL/ERR: set `core_done_o[core]`.
  - On `host_yumi_i` with cmd FAL/ERR: set the internal fail flag.
  - `core_done_o` bits and the fail flag are sticky until reset.
- Hold: while `host_v_o`=1 and `host_yumi_i`=0, all `host_*` outputs stay stable.

## Timing
- Reset (asynchronous assert, any cycle, including mid-transfer):
  - FIFOs empty, `rr_ptr`=0, finished/done/fail cleared.
  - Outputs: `host_v_o`=0, `host_cmd_o`=0, `host_core_o`=0, `host_data_o`=0, `core_done_o`=0, `done_o`=0, `pass_o`=0.
  - `cmt_ready_o` = all ones, because FIFOs are empty.
  - A pending record is discarded.
- Latency: a store accepted at edge t with empty FIFO and idle output appears on `host_v_o` from cycle t+2 (FIFO write at t, output load at t+1). No bypass path.
- Throughput: one record per cycle with `host_yumi_i` held high. Back-to-back loads occur on yumi cycles.
- Simultaneous push and pop on the same FIFO in one cycle: count is unchanged and data order is preserved.
- `core_done_o`, `done_o` and `pass_o` update the cycle after the consuming yumi edge.
- `cmt_ready_o` is a function of registered count only; it has no combinational path from `cmt_v_i` or `host_yumi_i`.

## Test plan
- Single core prints, `num_core_p`=2: core0 stores 0x41 to 0x8FFF_EFFF at cycle 5, with yumi held high.
  - Required: `host_v_o`=1 in cycle 7 with cmd=1, core=0, data=0x0041.
  - Required: `host_v_o`=0 in cycle 8.
- Round-robin fairness: both cores push 3 PRT_DEC records each in the same cycles, with yumi high.
  - Required: host order is core 0,1,0,1,0,1.
- Backpressure and full: yumi low; core0 pushes 5 prints, with `fifo_els_p`=4.
  - Required: `cmt_ready_o[0]`=0 after 4 FIFO entries plus 1 held in the output register.
  - Required: the record stays stable; raising yumi drains in order.
- Finish semantics:
  - Core0 stores 0x00000007 to 0xC00DEAD0; core1 stores 0xFFFF0003.
  - Required: PAS/7 and FAL/3 emitted; `done_o`=1 and `pass_o`=0 after both yumis.
  - A later core0 print is dropped.
- ERR and drop:
  - Store 0x12340001 to 0xC00DEAD0: required ERR, data=0.
  - Store to 0x8000_0000: required no host record, `cmt_ready_o` unaffected.
- Mid-operation reset: assert `reset_n_i` low while `host_v_o`=1 and the FIFOs are partially full.
  - Required: all outputs take their reset values immediately.
  - Required: nothing is emitted after release until new stores arrive.
